// File: rtl/dijkstra_pkg.sv
// Shared definitions for the approved-node selector: FSM state encodings and slot-index width helper.
package dijkstra_pkg;

    localparam int BUFFER_SIZE_PADRAO = 16;
    localparam int NODE_WIDTH_PADRAO  = 8;

    // A single-slot buffer still needs one index bit to keep port widths legal.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W_PADRAO = idx_width(BUFFER_SIZE_PADRAO);

    typedef logic [2:0] estado_t;

    localparam estado_t ST_IDLE    = 3'd0;
    localparam estado_t ST_CAPTURA = 3'd1;
    localparam estado_t ST_SCAN    = 3'd2;
    localparam estado_t ST_OFERTA  = 3'd3;
    localparam estado_t ST_FIM     = 3'd4;

endpackage

// File: rtl/seletor_aprovados_codificador.sv
// Combinational priority encoder over a slot mask, searching upward from a rotating base index
// (wrapping); reports the first set slot and whether any slot is set.
module codificador_prioridade
    import dijkstra_pkg::*;
#(
    parameter int  BUFFER_SIZE = BUFFER_SIZE_PADRAO,
    localparam int IDX_W       = idx_width(BUFFER_SIZE)
) (
    input  logic [BUFFER_SIZE-1:0] i_mascara,
    input  logic [IDX_W-1:0]       i_base,
    output logic [IDX_W-1:0]       o_indice,
    output logic                   o_algum
);

    localparam logic [IDX_W:0] TAMANHO = (IDX_W+1)'(BUFFER_SIZE);

    logic [IDX_W:0] w_pos;

    // Walk offsets from highest to lowest so the smallest offset from the base is the last write.
    always_comb begin
        w_pos    = '0;
        o_indice = '0;
        o_algum  = 1'b0;
        for (int k = BUFFER_SIZE - 1; k >= 0; k--) begin
            w_pos = {1'b0, i_base} + (IDX_W+1)'(k);
            if (w_pos >= TAMANHO) begin
                w_pos = w_pos - TAMANHO;
            end
            if (i_mascara[w_pos[IDX_W-1:0]]) begin
                o_indice = w_pos[IDX_W-1:0];
                o_algum  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seletor_aprovados.sv
// Snapshots the evaluator's approved-slot vector and offers approved nodes one at a time downstream.
// Optional build macro SELETOR_ROUND_ROBIN_EN enables a persistent rotating search pointer.
module seletor_aprovados
    import dijkstra_pkg::*;
#(
    parameter int  BUFFER_SIZE = BUFFER_SIZE_PADRAO,
    parameter int  NODE_WIDTH  = NODE_WIDTH_PADRAO,
    localparam int IDX_W       = idx_width(BUFFER_SIZE)
) (
    input  logic                   clk_in,
    input  logic                   rst_n_in,
    input  logic                   iniciar_in,
    input  logic                   abortar_in,
    input  logic [BUFFER_SIZE-1:0] aprovados_in,
    output logic [IDX_W-1:0]       slot_leitura_out,
    input  logic [NODE_WIDTH-1:0]  endereco_no_in,
    output logic                   no_valido_out,
    output logic [NODE_WIDTH-1:0]  no_endereco_out,
    input  logic                   no_pronto_in,
    output logic                   remover_out,
    output logic [NODE_WIDTH-1:0]  remover_endereco_out,
    output logic                   ocupado_out,
    output logic                   rodada_fim_out,
    output logic [IDX_W:0]         num_expandidos_out
);

    localparam logic [IDX_W:0] UM_CONTADOR = (IDX_W+1)'(1);

    estado_t                r_estado;
    logic [BUFFER_SIZE-1:0] r_mascara;
    logic [IDX_W-1:0]       r_slot;
    logic [NODE_WIDTH-1:0]  r_no_endereco;
    logic [NODE_WIDTH-1:0]  r_remover_endereco;
    logic                   r_remover;
    logic [IDX_W:0]         r_contador;

    logic [IDX_W-1:0]       w_base;
    logic [IDX_W-1:0]       w_escolhido;
    logic                   w_algum;
    logic [BUFFER_SIZE-1:0] w_um_quente;
    logic [BUFFER_SIZE-1:0] w_restante;
    logic                   w_aceite;

    assign w_um_quente = {{(BUFFER_SIZE-1){1'b0}}, 1'b1} << r_slot;
    assign w_restante  = r_mascara & ~w_um_quente;
    assign w_aceite    = (r_estado == ST_OFERTA) && no_pronto_in && !abortar_in;

`ifdef SELETOR_ROUND_ROBIN_EN
    localparam logic [IDX_W-1:0] ULTIMO_SLOT = IDX_W'(BUFFER_SIZE - 1);
    localparam logic [IDX_W-1:0] UM_SLOT     = IDX_W'(1);

    logic [IDX_W-1:0] r_ponteiro;

    // The pointer survives across rounds so slots skipped by an early abort get first pick next time.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_ponteiro <= '0;
        end else if (w_aceite) begin
            r_ponteiro <= (r_slot == ULTIMO_SLOT) ? '0 : r_slot + UM_SLOT;
        end
    end

    assign w_base = r_ponteiro;
`else
    assign w_base = '0;
`endif

    codificador_prioridade #(
        .BUFFER_SIZE (BUFFER_SIZE)
    ) u_codificador (
        .i_mascara (r_mascara),
        .i_base    (w_base),
        .o_indice  (w_escolhido),
        .o_algum   (w_algum)
    );

    // Abort outranks the handshake: an offer accepted in the abort cycle is never removed.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            r_estado           <= ST_IDLE;
            r_mascara          <= '0;
            r_slot             <= '0;
            r_no_endereco      <= '0;
            r_remover_endereco <= '0;
            r_remover          <= 1'b0;
            r_contador         <= '0;
        end else begin
            r_remover <= 1'b0;
            if ((r_estado != ST_IDLE) && abortar_in) begin
                r_estado <= ST_IDLE;
            end else begin
                case (r_estado)
                    ST_IDLE: begin
                        if (iniciar_in) begin
                            r_mascara  <= aprovados_in;
                            r_contador <= '0;
                            r_estado   <= ST_CAPTURA;
                        end
                    end
                    ST_CAPTURA: begin
                        r_estado <= (r_mascara == '0) ? ST_FIM : ST_SCAN;
                    end
                    ST_SCAN: begin
                        if (w_algum) begin
                            r_slot        <= w_escolhido;
                            r_no_endereco <= endereco_no_in;
                            r_estado      <= ST_OFERTA;
                        end else begin
                            r_estado <= ST_FIM;
                        end
                    end
                    ST_OFERTA: begin
                        if (no_pronto_in) begin
                            r_remover          <= 1'b1;
                            r_remover_endereco <= r_no_endereco;
                            r_mascara          <= w_restante;
                            r_contador         <= r_contador + UM_CONTADOR;
                            r_estado           <= (w_restante != '0) ? ST_SCAN : ST_FIM;
                        end
                    end
                    ST_FIM: begin
                        r_estado <= ST_IDLE;
                    end
                    default: begin
                        r_estado <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // The read index follows the encoder only while scanning so the evaluator sees a steady address.
    assign slot_leitura_out     = (r_estado == ST_SCAN) ? w_escolhido : r_slot;
    assign no_valido_out        = (r_estado == ST_OFERTA);
    assign no_endereco_out      = r_no_endereco;
    assign remover_out          = r_remover;
    assign remover_endereco_out = r_remover_endereco;
    assign ocupado_out          = (r_estado != ST_IDLE);
    assign rodada_fim_out       = (r_estado == ST_FIM);
    assign num_expandidos_out   = r_contador;

endmodule

// File: tb/tb_seletor_aprovados.sv
// Self-checking bench for seletor_aprovados: vector table, hand-written corner sequences and
// randomized rounds against a set-based reference model (honours SELETOR_ROUND_ROBIN_EN).
module tb_seletor_aprovados;

    localparam int BS = 16;

`ifdef SELETOR_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        iniciar_in;
    logic        abortar_in;
    logic [15:0] aprovados_in;
    logic [3:0]  slot_leitura_out;
    logic [7:0]  endereco_no_in;
    logic        no_valido_out;
    logic [7:0]  no_endereco_out;
    logic        no_pronto_in;
    logic        remover_out;
    logic [7:0]  remover_endereco_out;
    logic        ocupado_out;
    logic        rodada_fim_out;
    logic [4:0]  num_expandidos_out;

    int total = 0;
    int bad   = 0;
    int modelPtr;

    typedef struct {
        logic [15:0] mask;
        int          expCount;
        int          expFimAt;
        logic [7:0]  expFirst;
        logic [7:0]  expLast;
    } vec_t;

    vec_t vecs[7];

    always #5 clk_in = ~clk_in;

    function automatic logic [7:0] addrOf(input int s);
        return 8'((s * 17 + 3) % 256);
    endfunction

    // Reference pick: first approved slot at or after the pointer, wrapping; -1 when none left.
    function automatic int nextSlot(input logic [15:0] m, input int ptr);
        for (int k = 0; k < BS; k++) begin
            if (m[(ptr + k) % BS]) return (ptr + k) % BS;
        end
        return -1;
    endfunction

    assign endereco_no_in = addrOf(int'(slot_leitura_out));

    seletor_aprovados dut (
        .clk_in               (clk_in),
        .rst_n_in             (rst_n_in),
        .iniciar_in           (iniciar_in),
        .abortar_in           (abortar_in),
        .aprovados_in         (aprovados_in),
        .slot_leitura_out     (slot_leitura_out),
        .endereco_no_in       (endereco_no_in),
        .no_valido_out        (no_valido_out),
        .no_endereco_out      (no_endereco_out),
        .no_pronto_in         (no_pronto_in),
        .remover_out          (remover_out),
        .remover_endereco_out (remover_endereco_out),
        .ocupado_out          (ocupado_out),
        .rodada_fim_out       (rodada_fim_out),
        .num_expandidos_out   (num_expandidos_out)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name);
        total++;
        bad++;
        $display("[TB] FAIL %s: got unexpected event expected none", name);
    endtask

    task automatic applyStimulus(input logic ini, input logic [15:0] apr, input logic rdy, input logic abt);
        iniciar_in   = ini;
        aprovados_in = apr;
        no_pronto_in = rdy;
        abortar_in   = abt;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic doReset();
        rst_n_in = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        tick();
        rst_n_in = 1'b1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_slot"},   32'(slot_leitura_out), 32'(0));
        checkOutput({tag, "_valid"},  32'(no_valido_out), 32'(0));
        checkOutput({tag, "_addr"},   32'(no_endereco_out), 32'(0));
        checkOutput({tag, "_rem"},    32'(remover_out), 32'(0));
        checkOutput({tag, "_remadr"}, 32'(remover_endereco_out), 32'(0));
        checkOutput({tag, "_busy"},   32'(ocupado_out), 32'(0));
        checkOutput({tag, "_fim"},    32'(rodada_fim_out), 32'(0));
        checkOutput({tag, "_count"},  32'(num_expandidos_out), 32'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{16'h8421, 4, 10, 8'h03, 8'h02};
        vecs[1] = '{16'h0000, 0, 2, 8'h00, 8'h00};
        vecs[2] = '{16'h0001, 1, 4, 8'h03, 8'h03};
        vecs[3] = '{16'h8000, 1, 4, 8'h02, 8'h02};
        vecs[4] = '{16'h00F0, 4, 10, 8'h47, 8'h7A};
        vecs[5] = '{16'hFFFF, 16, 34, 8'h03, 8'h02};
        vecs[6] = '{16'h0100, 1, 4, 8'h8B, 8'h8B};

        // Reset state.
        doReset();
        checkAllZero("reset");

        // Table of full rounds with the expansion stage always ready.
        for (int v = 0; v < 7; v++) begin
            logic [15:0] mm;
            int ptr, offers, removes, fims, fimAt, s;
            logic [7:0] firstA, lastA, pendA;
            bit pend;
            doReset();
            mm = vecs[v].mask;
            ptr = 0; offers = 0; removes = 0; fims = 0; fimAt = -1;
            firstA = 8'h00; lastA = 8'h00; pendA = 8'h00; pend = 1'b0;
            applyStimulus(1'b1, vecs[v].mask, 1'b1, 1'b0);
            tick();
            applyStimulus(1'b0, ~vecs[v].mask, 1'b1, 1'b0);
            for (int c = 1; c <= 40; c++) begin
                checkOutput("tbl_remover", 32'(remover_out), 32'(pend));
                if (pend && remover_out) checkOutput("tbl_rem_addr", 32'(remover_endereco_out), 32'(pendA));
                if (remover_out) removes++;
                pend = 1'b0;
                if (rodada_fim_out) begin
                    fims++;
                    fimAt = c;
                end
                if (no_valido_out) begin
                    s = nextSlot(mm, ptr);
                    if (offers == 0) firstA = no_endereco_out;
                    lastA = no_endereco_out;
                    offers++;
                    if (s < 0) begin
                        reportFail("tbl_offer_extra");
                    end else begin
                        checkOutput("tbl_offer_addr", 32'(no_endereco_out), 32'(addrOf(s)));
                        mm[s] = 1'b0;
                        if (RR) ptr = (s + 1) % BS;
                        pend  = 1'b1;
                        pendA = addrOf(s);
                    end
                end
                tick();
            end
            checkOutput("tbl_offers", 32'(offers), 32'(vecs[v].expCount));
            checkOutput("tbl_removes", 32'(removes), 32'(vecs[v].expCount));
            checkOutput("tbl_count", 32'(num_expandidos_out), 32'(vecs[v].expCount));
            checkOutput("tbl_fims", 32'(fims), 32'(1));
            checkOutput("tbl_fim_at", 32'(fimAt), 32'(vecs[v].expFimAt));
            if (vecs[v].expCount > 0) begin
                checkOutput("tbl_first", 32'(firstA), 32'(vecs[v].expFirst));
                checkOutput("tbl_last", 32'(lastA), 32'(vecs[v].expLast));
            end
        end

        // Reset while an offer is pending and being accepted: reset wins, nothing removed.
        doReset();
        applyStimulus(1'b1, 16'h0003, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rstmid_valid_before", 32'(no_valido_out), 32'(1));
        rst_n_in = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        checkAllZero("rstmid");
        rst_n_in = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        checkOutput("rstmid_rem_after", 32'(remover_out), 32'(0));
        checkOutput("rstmid_busy_after", 32'(ocupado_out), 32'(0));

        // Backpressure on first offer of slots 2 and 5.
        doReset();
        applyStimulus(1'b1, 16'h0024, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_valid_held", 32'(no_valido_out), 32'(1));
            checkOutput("bp_addr_held", 32'(no_endereco_out), 32'(8'h25));
            checkOutput("bp_no_remove", 32'(remover_out), 32'(0));
            tick();
        end
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        checkOutput("bp_rem1", 32'(remover_out), 32'(1));
        checkOutput("bp_rem1_addr", 32'(remover_endereco_out), 32'(8'h25));
        checkOutput("bp_valid_drop", 32'(no_valido_out), 32'(0));
        tick();
        checkOutput("bp_offer2", 32'(no_endereco_out), 32'(8'h58));
        checkOutput("bp_offer2_valid", 32'(no_valido_out), 32'(1));
        tick();
        checkOutput("bp_rem2_addr", 32'(remover_endereco_out), 32'(8'h58));
        checkOutput("bp_rem2", 32'(remover_out), 32'(1));
        checkOutput("bp_fim", 32'(rodada_fim_out), 32'(1));
        checkOutput("bp_count", 32'(num_expandidos_out), 32'(2));
        tick();
        checkOutput("bp_idle", 32'(ocupado_out), 32'(0));

        // Abort coinciding with the second handshake; iniciar while busy is ignored.
        doReset();
        applyStimulus(1'b1, 16'h0003, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0);
        tick();
        tick();
        checkOutput("ab_offer1", 32'(no_endereco_out), 32'(8'h03));
        tick();
        checkOutput("ab_rem1", 32'(remover_out), 32'(1));
        tick();
        checkOutput("ab_offer2", 32'(no_endereco_out), 32'(8'h14));
        checkOutput("ab_count_mid", 32'(num_expandidos_out), 32'(1));
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b1);
        tick();
        checkOutput("ab_busy", 32'(ocupado_out), 32'(0));
        checkOutput("ab_no_rem", 32'(remover_out), 32'(0));
        checkOutput("ab_no_fim", 32'(rodada_fim_out), 32'(0));
        checkOutput("ab_count", 32'(num_expandidos_out), 32'(1));
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        checkOutput("ab_no_rem_late", 32'(remover_out), 32'(0));
        checkOutput("ab_no_fim_late", 32'(rodada_fim_out), 32'(0));

        // Second round after accepting slot 0 and aborting: pick order depends on the build.
        doReset();
        applyStimulus(1'b1, 16'h0003, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        tick();
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 16'h0003, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rr_first_pick", 32'(no_endereco_out), 32'(RR ? addrOf(1) : addrOf(0)));
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        tick();

        // Randomized rounds against the set-based model.
        doReset();
        modelPtr = 0;
        for (int r = 0; r < 40; r++) begin
            logic [15:0] mm;
            int cnt, cyc, expFimAt, s;
            bit pend, done, rdy, abt, ini;
            logic [7:0] pendA, expA;
            mm = 16'($urandom) & 16'($urandom);
            if ($urandom_range(0, 7) == 0) mm = 16'h0000;
            cnt = 0; cyc = 0; pend = 1'b0; done = 1'b0; pendA = 8'h00; expA = 8'h00; s = -1;
            expFimAt = (mm == 16'h0000) ? 2 : -1;
            applyStimulus(1'b1, mm, 1'b0, 1'b0);
            tick();
            while (!done && cyc < 200) begin
                cyc++;
                checkOutput("rnd_remover", 32'(remover_out), 32'(pend));
                if (pend && remover_out) checkOutput("rnd_rem_addr", 32'(remover_endereco_out), 32'(pendA));
                pend = 1'b0;
                checkOutput("rnd_fim", 32'(rodada_fim_out), 32'(cyc == expFimAt));
                s = -1;
                if (no_valido_out) begin
                    s = nextSlot(mm, modelPtr);
                    if (s < 0) begin
                        reportFail("rnd_offer_extra");
                    end else begin
                        expA = addrOf(s);
                        checkOutput("rnd_offer_addr", 32'(no_endereco_out), 32'(expA));
                    end
                end
                if (!ocupado_out) begin
                    checkOutput("rnd_count", 32'(num_expandidos_out), 32'(cnt));
                    done = 1'b1;
                end else begin
                    rdy = ($urandom_range(0, 3) != 0);
                    abt = ($urandom_range(0, 49) == 0);
                    ini = ($urandom_range(0, 3) == 0);
                    if (no_valido_out && s >= 0 && rdy && !abt) begin
                        mm[s] = 1'b0;
                        cnt++;
                        pend  = 1'b1;
                        pendA = expA;
                        if (RR) modelPtr = (s + 1) % BS;
                        if (mm == 16'h0000) expFimAt = cyc + 1;
                    end
                    if (abt) expFimAt = -1;
                    applyStimulus(ini, 16'($urandom), rdy, abt);
                    tick();
                end
            end
            if (!done) begin
                reportFail("rnd_timeout");
                break;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
